// File: rtl/sum_bcd_display.sv
// sum_bcd_display: display stage for an 8-bit binary result.
// A sequential double-dabble engine converts the value to three BCD digits,
// one shift per clock. The result drives registered 7-segment patterns for
// the units, tens and hundreds digits, with optional leading-zero blanking.
// No divider sits on the display outputs.
module sum_bcd_display #(
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic        clk,
    input  logic        rst_a_n,
    input  logic        bin_valid,
    input  logic [7:0]  bin_in,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd_out,
    output logic [0:6]  unidades,
    output logic [0:6]  decenas,
    output logic [0:6]  centenas
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    localparam logic [0:6] SEG_BLANK = 7'b1111111;
    localparam logic [0:6] SEG_ZERO  = 7'b0000001;
    // Tens and hundreds come out of reset blank when leading zeros are suppressed.
    localparam logic [0:6] SEG_LEAD_RST = BLANK_LZ ? SEG_BLANK : SEG_ZERO;

    state_t      state_q, state_d;
    logic [19:0] shift_q, shift_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        done_q, done_d;
    logic [11:0] bcd_q, bcd_d;
    logic [0:6]  uni_q, uni_d;
    logic [0:6]  dec_q, dec_d;
    logic [0:6]  cen_q, cen_d;
    logic [19:0] adj;

    // Segment pattern for one BCD digit; index 0 is segment a, 0 means lit.
    function automatic logic [0:6] seg7(input logic [3:0] d);
        logic [0:6] s;
        case (d)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Double-dabble correction: a nibble of 5 or more gets 3 added before the shift.
    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    // All three BCD nibbles are corrected in parallel from their pre-add values.
    always_comb begin
        adj = {add3(shift_q[19:16]), add3(shift_q[15:12]), add3(shift_q[11:8]), shift_q[7:0]};
    end

    // Next-state logic: accept in IDLE, eight correct-and-shift steps, then latch the digits.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        bcd_d   = bcd_q;
        uni_d   = uni_q;
        dec_d   = dec_q;
        cen_d   = cen_q;
        case (state_q)
            IDLE: begin
                if (bin_valid) begin
                    shift_d = {12'h000, bin_in};
                    cnt_d   = 4'd0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                shift_d = {adj[18:0], 1'b0};
                cnt_d   = cnt_q + 4'd1;
                if (cnt_q == 4'd7) begin
                    state_d = LATCH;
                end
            end
            LATCH: begin
                bcd_d  = shift_q[19:8];
                done_d = 1'b1;
                uni_d  = seg7(shift_q[11:8]);
                dec_d  = seg7(shift_q[15:12]);
                cen_d  = seg7(shift_q[19:16]);
                if (BLANK_LZ) begin
                    // An inner zero stays visible: tens blank only with zero hundreds.
                    if (shift_q[19:16] == 4'd0) begin
                        cen_d = SEG_BLANK;
                        if (shift_q[15:12] == 4'd0) begin
                            dec_d = SEG_BLANK;
                        end
                    end
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any conversion in flight.
    always_ff @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            state_q <= IDLE;
            shift_q <= 20'h00000;
            cnt_q   <= 4'd0;
            done_q  <= 1'b0;
            bcd_q   <= 12'h000;
            uni_q   <= SEG_ZERO;
            dec_q   <= SEG_LEAD_RST;
            cen_q   <= SEG_LEAD_RST;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            bcd_q   <= bcd_d;
            uni_q   <= uni_d;
            dec_q   <= dec_d;
            cen_q   <= cen_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign bcd_out  = bcd_q;
    assign unidades = uni_q;
    assign decenas  = dec_q;
    assign centenas = cen_q;

endmodule

// File: tb/tb_sum_bcd_display.sv
// Testbench for sum_bcd_display: directed conversions on two instances,
// one blanking leading zeros and one showing all three digits.
module tb_sum_bcd_display;

    logic        clk;
    logic        rst_a_n;
    logic        bin_valid;
    logic [7:0]  bin_in;
    logic        busy_a, done_a, busy_b, done_b;
    logic [11:0] bcd_a, bcd_b;
    logic [0:6]  uni_a, dec_a, cen_a, uni_b, dec_b, cen_b;

    int n_checks = 0;
    int n_fail   = 0;

    sum_bcd_display #(.BLANK_LZ(1'b1)) dut_a (
        .clk(clk), .rst_a_n(rst_a_n), .bin_valid(bin_valid), .bin_in(bin_in),
        .busy(busy_a), .done(done_a), .bcd_out(bcd_a),
        .unidades(uni_a), .decenas(dec_a), .centenas(cen_a)
    );

    sum_bcd_display #(.BLANK_LZ(1'b0)) dut_b (
        .clk(clk), .rst_a_n(rst_a_n), .bin_valid(bin_valid), .bin_in(bin_in),
        .busy(busy_b), .done(done_b), .bcd_out(bcd_b),
        .unidades(uni_b), .decenas(dec_b), .centenas(cen_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one value for a single accept edge, then wait (bounded) for done.
    // lat = number of edges after the accept edge at which done was seen, -1 if never.
    task automatic run_conv(input logic [7:0] v, output int lat);
        lat = -1;
        bin_in    = v;
        bin_valid = 1'b1;
        tick();
        bin_valid = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (done_a && lat < 0) lat = i;
        end
    endtask

    task automatic test_reset();
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy_a); end
        n_checks++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done_a); end
        n_checks++; if (bcd_a !== 12'h000) begin n_fail++; $display("FAIL reset_bcd got %h want 000", bcd_a); end
        n_checks++; if (uni_a !== 7'b0000001) begin n_fail++; $display("FAIL reset_uni got %b want 0000001", uni_a); end
        n_checks++; if (dec_a !== 7'b1111111) begin n_fail++; $display("FAIL reset_dec got %b want 1111111", dec_a); end
        n_checks++; if (cen_a !== 7'b1111111) begin n_fail++; $display("FAIL reset_cen got %b want 1111111", cen_a); end
        n_checks++; if (dec_b !== 7'b0000001 || cen_b !== 7'b0000001 || busy_b !== 1'b0 || done_b !== 1'b0)
            begin n_fail++; $display("FAIL reset_noblank got dec=%b cen=%b busy=%b done=%b want 0000001 0000001 0 0", dec_b, cen_b, busy_b, done_b); end
    endtask

    task automatic test_latency_120();
        int lat;
        int busy_bad;
        busy_bad = 0;
        bin_in    = 8'd120;
        bin_valid = 1'b1;
        tick();                      // accept edge k
        bin_valid = 1'b0;
        bin_in    = 8'd3;            // later changes must not matter
        n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL lat_busy_k got %b want 1", busy_a); end
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i <= 8 && (busy_a !== 1'b1 || done_a !== 1'b0)) busy_bad++;
            if (done_a && lat < 0) lat = i;
            if (i == 9) begin
                n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL lat_busy_k9 got %b want 0", busy_a); end
            end
            if (i == 10) begin
                n_checks++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL lat_done_width got %b want 0", done_a); end
            end
        end
        n_checks++; if (busy_bad != 0) begin n_fail++; $display("FAIL lat_busy_window got %0d bad cycles want 0", busy_bad); end
        n_checks++; if (lat != 9) begin n_fail++; $display("FAIL lat_120 got %0d edges want 9", lat); end
        n_checks++; if (bcd_a !== 12'h120) begin n_fail++; $display("FAIL bcd_120 got %h want 120", bcd_a); end
        n_checks++; if (cen_a !== 7'b1001111) begin n_fail++; $display("FAIL cen_120 got %b want 1001111", cen_a); end
        n_checks++; if (dec_a !== 7'b0010010) begin n_fail++; $display("FAIL dec_120 got %b want 0010010", dec_a); end
        n_checks++; if (uni_a !== 7'b0000001) begin n_fail++; $display("FAIL uni_120 got %b want 0000001", uni_a); end
    endtask

    task automatic test_values();
        int lat;
        run_conv(8'd255, lat);
        n_checks++; if (lat != 9) begin n_fail++; $display("FAIL lat_255 got %0d want 9", lat); end
        n_checks++; if (bcd_a !== 12'h255) begin n_fail++; $display("FAIL bcd_255 got %h want 255", bcd_a); end
        n_checks++; if ({cen_a, dec_a, uni_a} !== {7'b0010010, 7'b0100100, 7'b0100100})
            begin n_fail++; $display("FAIL seg_255 got %b %b %b want 0010010 0100100 0100100", cen_a, dec_a, uni_a); end
        run_conv(8'd0, lat);
        n_checks++; if (bcd_a !== 12'h000) begin n_fail++; $display("FAIL bcd_0 got %h want 000", bcd_a); end
        n_checks++; if ({cen_a, dec_a, uni_a} !== {7'b1111111, 7'b1111111, 7'b0000001})
            begin n_fail++; $display("FAIL seg_0 got %b %b %b want 1111111 1111111 0000001", cen_a, dec_a, uni_a); end
    endtask

    task automatic test_blanking();
        int lat;
        run_conv(8'd7, lat);
        n_checks++; if ({cen_a, dec_a, uni_a} !== {7'b1111111, 7'b1111111, 7'b0001111})
            begin n_fail++; $display("FAIL blank_7 got %b %b %b want 1111111 1111111 0001111", cen_a, dec_a, uni_a); end
        n_checks++; if ({cen_b, dec_b, uni_b} !== {7'b0000001, 7'b0000001, 7'b0001111})
            begin n_fail++; $display("FAIL noblank_7 got %b %b %b want 0000001 0000001 0001111", cen_b, dec_b, uni_b); end
        n_checks++; if (bcd_b !== 12'h007) begin n_fail++; $display("FAIL noblank_bcd_7 got %h want 007", bcd_b); end
        run_conv(8'd105, lat);
        n_checks++; if ({cen_a, dec_a, uni_a} !== {7'b1001111, 7'b0000001, 7'b0100100})
            begin n_fail++; $display("FAIL inner_zero_105 got %b %b %b want 1001111 0000001 0100100", cen_a, dec_a, uni_a); end
        n_checks++; if (bcd_a !== 12'h105) begin n_fail++; $display("FAIL bcd_105 got %h want 105", bcd_a); end
    endtask

    task automatic test_busy_ignore();
        int dones;
        dones = 0;
        bin_in    = 8'd42;
        bin_valid = 1'b1;
        tick();                      // accept edge k
        bin_valid = 1'b0;
        tick();                      // k+1
        tick();                      // k+2
        bin_in    = 8'd99;
        bin_valid = 1'b1;
        tick();                      // k+3, must be ignored
        bin_valid = 1'b0;
        for (int i = 4; i <= 25; i++) begin
            tick();
            if (done_a) dones++;
            if (i == 9) begin
                n_checks++; if (done_a !== 1'b1) begin n_fail++; $display("FAIL ign_done_k9 got %b want 1", done_a); end
            end
        end
        n_checks++; if (dones != 1) begin n_fail++; $display("FAIL ign_done_count got %0d want 1", dones); end
        n_checks++; if (bcd_a !== 12'h042) begin n_fail++; $display("FAIL ign_bcd got %h want 042", bcd_a); end
        n_checks++; if ({cen_a, dec_a, uni_a} !== {7'b1111111, 7'b1001100, 7'b0010010})
            begin n_fail++; $display("FAIL ign_seg got %b %b %b want 1111111 1001100 0010010", cen_a, dec_a, uni_a); end
    endtask

    task automatic test_reset_abort();
        int dones;
        int lat;
        dones = 0;
        bin_in    = 8'd200;
        bin_valid = 1'b1;
        tick();                      // accept edge k
        bin_valid = 1'b0;
        tick(); tick(); tick();      // k+1..k+3
        rst_a_n = 1'b0;              // asynchronous, before edge k+4
        #1;
        n_checks++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin n_fail++; $display("FAIL abort_ctrl got busy=%b done=%b want 0 0", busy_a, done_a); end
        n_checks++; if (bcd_a !== 12'h000) begin n_fail++; $display("FAIL abort_bcd got %h want 000", bcd_a); end
        n_checks++; if ({cen_a, dec_a, uni_a} !== {7'b1111111, 7'b1111111, 7'b0000001})
            begin n_fail++; $display("FAIL abort_seg got %b %b %b want 1111111 1111111 0000001", cen_a, dec_a, uni_a); end
        tick(); tick();
        rst_a_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done_a || busy_a) dones++;
        end
        n_checks++; if (dones != 0) begin n_fail++; $display("FAIL abort_no_done got %0d active cycles want 0", dones); end
        run_conv(8'd15, lat);
        n_checks++; if (lat != 9) begin n_fail++; $display("FAIL lat_15 got %0d want 9", lat); end
        n_checks++; if (bcd_a !== 12'h015) begin n_fail++; $display("FAIL bcd_15 got %h want 015", bcd_a); end
        n_checks++; if ({cen_a, dec_a, uni_a} !== {7'b1111111, 7'b1001111, 7'b0100100})
            begin n_fail++; $display("FAIL seg_15 got %b %b %b want 1111111 1001111 0100100", cen_a, dec_a, uni_a); end
    endtask

    initial begin
        rst_a_n   = 1'b0;
        bin_valid = 1'b0;
        bin_in    = 8'd0;
        tick(); tick();
        rst_a_n = 1'b1;
        tick(); tick();
        test_reset();
        test_latency_120();
        test_values();
        test_blanking();
        test_busy_ignore();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
